lut_update_ctrl: RTL and testbench

//  Frame-synchronous loader for the RGB LUT (vp_0) in the pixel-clock domain.

---
 rtl/lut_update_ctrl_if.sv | 28 ++
 rtl/lut_update_ctrl.sv | 117 +++++++++++
 tb/tb_lut_update_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_update_ctrl_if.sv
// Host-side configuration bus of lut_update_ctrl.
//  cfg_valid/cfg_ready  staging-FIFO write handshake
//  cfg_sel/addr/data    LUT entry (sel 0=R 1=G 2=B 3=reserved)
//  cfg_commit           1-cycle pulse, apply staged entries at next blanking
//  cfg_pending          commit accepted, not yet finished
//  cfg_done             1-cycle pulse, all staged entries written
//  cfg_split            sticky, drain spanned more than one blanking interval
interface lut_update_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       cfg_commit;
  logic       cfg_pending;
  logic       cfg_done;
  logic       cfg_split;

  modport master (
    output cfg_valid, cfg_sel, cfg_addr, cfg_data, cfg_commit,
    input  cfg_ready, cfg_pending, cfg_done, cfg_split
  );

  modport slave (
    input  cfg_valid, cfg_sel, cfg_addr, cfg_data, cfg_commit,
    output cfg_ready, cfg_pending, cfg_done, cfg_split
  );
endinterface

// File: rtl/lut_update_ctrl.sv
// Frame-synchronous RGB LUT loader (pixel-clock domain).
// Host writes are staged in a FIFO and only pushed into the LUT after a
// commit, during vertical blanking, so no frame ever sees a mixed table.
// Ports:
//  clk, rst_n        pixel clock, async active-low reset
//  de_in, v_sync_in  video timing shared with the LUT datapath
//  cfg               host bus (lut_update_ctrl_if.slave)
//  lut_wr_*          registered LUT write port
module lut_update_ctrl #(
  parameter int DEPTH  = 64,
  parameter int AW     = 6,
  parameter bit VS_POL = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                de_in,
  input  logic                v_sync_in,
  lut_update_ctrl_if.slave    cfg,
  output logic                lut_wr_en,
  output logic [1:0]          lut_wr_sel,
  output logic [7:0]          lut_wr_addr,
  output logic [7:0]          lut_wr_data
);

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] addr;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ARMED, DRAIN, DONE} state_t;

  state_t      state;
  entry_t      mem [DEPTH];
  entry_t      head;
  logic [AW:0] wr_ptr, rd_ptr, level;
  logic        empty, full, last, push;
  logic        vs_act, vs_act_q, vs_rise;
  logic        done_q, split_q, ready;

  // Extra pointer MSB distinguishes full from empty; wrap is free.
  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign last  = (level == (AW+1)'(1));
  assign head  = mem[rd_ptr[AW-1:0]];

  assign vs_act  = (v_sync_in == VS_POL);
  assign vs_rise = vs_act && !vs_act_q;

  // Gated by rst_n so every output reads 0 while reset is held.
  assign ready = rst_n && (state == IDLE) && !full;
  assign push  = cfg.cfg_valid && ready;

  assign cfg.cfg_ready   = ready;
  assign cfg.cfg_pending = (state != IDLE);
  assign cfg.cfg_done    = done_q;
  assign cfg.cfg_split   = split_q;

  // Storage only; entries are invalidated by the pointer reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{sel: cfg.cfg_sel, addr: cfg.cfg_addr, data: cfg.cfg_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      vs_act_q    <= 1'b0;
      done_q      <= 1'b0;
      split_q     <= 1'b0;
      lut_wr_en   <= 1'b0;
      lut_wr_sel  <= '0;
      lut_wr_addr <= '0;
      lut_wr_data <= '0;
    end else begin
      vs_act_q  <= vs_act;
      done_q    <= 1'b0;
      lut_wr_en <= 1'b0;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      case (state)
        IDLE: if (cfg.cfg_commit) begin
          if (empty) done_q <= 1'b1;
          else begin
            state   <= ARMED;
            split_q <= 1'b0;
          end
        end
        // Commit and vs_rise in the same cycle: the rise is missed here
        // because vs_act_q already follows it, so the next frame is used.
        ARMED: if (vs_rise) state <= DRAIN;
        DRAIN: begin
          // Active video with more than one entry left: park until the
          // next blanking. The final entry is always allowed to finish.
          if (de_in && !last) begin
            split_q <= 1'b1;
            state   <= ARMED;
          end else begin
            rd_ptr      <= rd_ptr + (AW+1)'(1);
            lut_wr_en   <= (head.sel != 2'd3);
            lut_wr_sel  <= head.sel;
            lut_wr_addr <= head.addr;
            lut_wr_data <= head.data;
            if (last) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_update_ctrl.sv
module tb_lut_update_ctrl;
  logic clk = 1'b0;
  logic rst_n, de_in, vs;
  wire  vs_n = ~vs;

  logic       wa_en, wb_en;
  logic [1:0] wa_sel, wb_sel;
  logic [7:0] wa_addr, wb_addr, wa_data, wb_data;

  int checks = 0, failures = 0;
  int wr_a = 0, wr_b = 0, done_a = 0, done_b = 0;
  logic [17:0] qa[$], qb[$];
  logic [17:0] ea, eb;

  always #5 clk = ~clk;

  lut_update_ctrl_if ifa();
  lut_update_ctrl_if ifb();

  // Both builds see the same host traffic; dut_b has active-low vsync.
  assign ifb.cfg_valid  = ifa.cfg_valid;
  assign ifb.cfg_sel    = ifa.cfg_sel;
  assign ifb.cfg_addr   = ifa.cfg_addr;
  assign ifb.cfg_data   = ifa.cfg_data;
  assign ifb.cfg_commit = ifa.cfg_commit;

  lut_update_ctrl #(.DEPTH(64), .AW(6), .VS_POL(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .de_in(de_in), .v_sync_in(vs), .cfg(ifa),
    .lut_wr_en(wa_en), .lut_wr_sel(wa_sel), .lut_wr_addr(wa_addr), .lut_wr_data(wa_data));

  lut_update_ctrl #(.DEPTH(64), .AW(6), .VS_POL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .de_in(de_in), .v_sync_in(vs_n), .cfg(ifb),
    .lut_wr_en(wb_en), .lut_wr_sel(wb_sel), .lut_wr_addr(wb_addr), .lut_wr_data(wb_data));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every LUT write must match the oldest staged entry.
  always @(negedge clk) begin
    if (wa_en === 1'b1) begin
      wr_a++;
      chk("a_write_expected", qa.size() != 0, 1);
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        chk("a_write_entry", {wa_sel, wa_addr, wa_data}, ea);
      end
    end
    if (wb_en === 1'b1) begin
      wr_b++;
      chk("b_write_expected", qb.size() != 0, 1);
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        chk("b_write_entry", {wb_sel, wb_addr, wb_data}, eb);
      end
    end
    if (ifa.cfg_done === 1'b1) begin
      done_a++;
      chk("a_done_all_written", qa.size(), 0);
    end
    if (ifb.cfg_done === 1'b1) begin
      done_b++;
      chk("b_done_all_written", qb.size(), 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stage(input logic [1:0] s, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    ifa.cfg_valid = 1'b1;
    ifa.cfg_sel   = s;
    ifa.cfg_addr  = a;
    ifa.cfg_data  = d;
    while (ifa.cfg_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("stage_ready", ifa.cfg_ready, 1);
    step();
    ifa.cfg_valid = 1'b0;
    if (s != 2'd3) begin
      qa.push_back({s, a, d});
      qb.push_back({s, a, d});
    end
  endtask

  task automatic commit();
    ifa.cfg_commit = 1'b1;
    step();
    ifa.cfg_commit = 1'b0;
  endtask

  task automatic vframe();
    vs = 1'b1;
    repeat (3) step();
    vs = 1'b0;
    step();
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while ((done_a < target || done_b < target) && n < 500) begin
      step();
      n++;
    end
    chk("wait_done", (done_a >= target) && (done_b >= target), 1);
  endtask

  int w0, d0;

  initial begin
    rst_n = 1'b0; de_in = 1'b0; vs = 1'b0;
    ifa.cfg_valid = 1'b0; ifa.cfg_sel = '0; ifa.cfg_addr = '0;
    ifa.cfg_data = '0; ifa.cfg_commit = 1'b0;
    repeat (2) step();

    // Reset state
    chk("rst_ready", ifa.cfg_ready, 0);
    chk("rst_pending", ifa.cfg_pending, 0);
    chk("rst_done", ifa.cfg_done, 0);
    chk("rst_split", ifa.cfg_split, 0);
    chk("rst_wr_en", wa_en, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", ifa.cfg_ready, 1);
    chk("post_rst_ready_b", ifb.cfg_ready, 1);
    chk("post_rst_pending", ifa.cfg_pending, 0);

    // Basic load, 2-cycle latency from the vsync edge
    stage(2'd0, 8'h10, 8'hAA);
    stage(2'd1, 8'h20, 8'hBB);
    stage(2'd2, 8'hFF, 8'h01);
    commit();
    chk("basic_pending", ifa.cfg_pending, 1);
    chk("basic_ready_armed", ifa.cfg_ready, 0);
    w0 = wr_a;
    vs = 1'b1;
    step();
    chk("lat_edge1_a", wa_en, 0);
    chk("lat_edge1_b", wb_en, 0);
    step();
    chk("lat_edge2_a", {wa_en, wa_sel, wa_addr, wa_data}, {1'b1, 2'd0, 8'h10, 8'hAA});
    chk("lat_edge2_b", {wb_en, wb_sel, wb_addr, wb_data}, {1'b1, 2'd0, 8'h10, 8'hAA});
    step();
    chk("basic_w2_en", wa_en, 1);
    step();
    chk("basic_w3_en", wa_en, 1);
    chk("basic_done", ifa.cfg_done, 1);
    chk("basic_done_b", ifb.cfg_done, 1);
    step();
    chk("basic_done_pulse", ifa.cfg_done, 0);
    chk("basic_idle", ifa.cfg_pending, 0);
    chk("basic_split", ifa.cfg_split, 0);
    vs = 1'b0;
    de_in = 1'b1;
    repeat (5) step();
    de_in = 1'b0;
    chk("basic_count_a", wr_a - w0, 3);
    chk("basic_count_b", wr_b - w0, 3);

    // Full FIFO
    for (int i = 0; i < 64; i++) stage(2'($urandom_range(0, 2)), 8'(i), 8'($urandom));
    ifa.cfg_valid = 1'b1;
    repeat (3) step();
    chk("full_ready", ifa.cfg_ready, 0);
    ifa.cfg_valid = 1'b0;
    w0 = wr_a; d0 = done_a;
    commit();
    vframe();
    wait_done(d0 + 1);
    chk("full_count", wr_a - w0, 64);
    chk("full_q_empty", qa.size(), 0);

    // Split across two blanking intervals
    for (int i = 0; i < 64; i++) stage(2'($urandom_range(0, 2)), 8'(255 - i), 8'($urandom));
    w0 = wr_a; d0 = done_a;
    commit();
    vs = 1'b1;
    repeat (3) step();
    vs = 1'b0;
    repeat (18) step();
    de_in = 1'b1;
    repeat (2) step();
    chk("split_first_burst", wr_a - w0, 20);
    chk("split_first_burst_b", wr_b - w0, 20);
    chk("split_flag", ifa.cfg_split, 1);
    chk("split_pending", ifa.cfg_pending, 1);
    repeat (10) step();
    de_in = 1'b0;
    chk("split_hold", wr_a - w0, 20);
    vframe();
    wait_done(d0 + 1);
    chk("split_total", wr_a - w0, 64);
    chk("split_sticky", ifa.cfg_split, 1);
    chk("split_idle", ifa.cfg_pending, 0);

    // Empty commit
    w0 = wr_a;
    commit();
    chk("empty_done", ifa.cfg_done, 1);
    chk("empty_pending", ifa.cfg_pending, 0);
    step();
    chk("empty_done_pulse", ifa.cfg_done, 0);

    // Commit coinciding with vs_rise, commit while ARMED, sel=3 dropped
    stage(2'd1, 8'h33, 8'h44);
    stage(2'd3, 8'h55, 8'h66);
    d0 = done_a;
    ifa.cfg_commit = 1'b1;
    vs = 1'b1;
    step();
    ifa.cfg_commit = 1'b0;
    chk("samecyc_split_cleared", ifa.cfg_split, 0);
    repeat (4) step();
    chk("samecyc_no_drain", wr_a - w0, 0);
    chk("samecyc_pending", ifa.cfg_pending, 1);
    commit();
    chk("armed_commit_ignored", ifa.cfg_pending, 1);
    chk("armed_commit_no_done", ifa.cfg_done, 0);
    vs = 1'b0;
    step();
    vframe();
    wait_done(d0 + 1);
    chk("sel3_count", wr_a - w0, 1);
    chk("sel3_count_b", wr_b - w0, 1);

    // Reset in the middle of a drain
    for (int i = 0; i < 8; i++) stage(2'd2, 8'(i), 8'(i * 3));
    commit();
    vs = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", wa_en, 0);
    chk("midrst_wr_en_b", wb_en, 0);
    chk("midrst_pending", ifa.cfg_pending, 0);
    chk("midrst_ready", ifa.cfg_ready, 0);
    qa.delete();
    qb.delete();
    vs = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("midrst_post_ready", ifa.cfg_ready, 1);
    commit();
    chk("midrst_entries_lost", ifa.cfg_done, 1);
    w0 = wr_a;
    vframe();
    repeat (5) step();
    chk("midrst_no_writes", wr_a - w0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
